// File: rtl/sobel_context_3x3.sv
// sobel_context_3x3
//
// Downstream stage of the BRAM line-delay pair. Three vertically aligned taps
// are shifted into a 3x3 register window. The block computes the Sobel
// magnitude |Gx|+|Gy|, saturates it to pixel width and masks the image border.
// The stream syncs are delayed so that they line up with dout.
//
// Ports:
//   clk                        pixel clock, rising edge
//   rst                        synchronous active-high reset, honoured only while ce=1
//   ce                         clock enable for every register in the block
//   row0 / row1 / row2         taps: two lines delayed, one line delayed, current line
//   in_de / in_hsync / in_vsync input stream syncs
//   h_size                     active pixels per line (3 .. 2^COL_W-1), static per frame
//   dout                       saturated gradient magnitude, 0 on border / blanking
//   out_de / out_hsync / out_vsync  syncs delayed by 4 ce edges to match dout

module sobel_context_3x3 #(
    parameter int WIDTH = 8,
    parameter int COL_W = 11,
    parameter int ROW_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] row0,
    input  logic [WIDTH-1:0] row1,
    input  logic [WIDTH-1:0] row2,
    input  logic             in_de,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic [COL_W-1:0] h_size,
    output logic [WIDTH-1:0] dout,
    output logic             out_de,
    output logic             out_hsync,
    output logic             out_vsync
);

    localparam int GW = WIDTH + 3;
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [ROW_W-1:0] LINE_ONE = ROW_W'(1);
    localparam logic [GW-1:0]    G_ONE    = GW'(1);

    // Window columns: c0 oldest (left), c1 centre, c2 newest (right)
    logic [WIDTH-1:0] c0_r0, c0_r1, c0_r2;
    logic [WIDTH-1:0] c1_r0, c1_r1, c1_r2;
    logic [WIDTH-1:0] c2_r0, c2_r1, c2_r2;

    // Bit 0 is sync stage 1, which carries the de of the pixel now entering the centre
    logic [3:0] de_dly, hs_dly, vs_dly;

    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] line_cnt;
    logic             frame_synced;
    logic             border_w, border_g;

    // Gradients held as two's complement in GW bits
    logic [GW-1:0] gx, gy;

    logic [GW-1:0]    gx_pos, gx_neg, gy_pos, gy_neg;
    logic [GW-1:0]    abs_gx, abs_gy, mag;
    logic [WIDTH-1:0] mag_sat;
    logic             vs_rise, de_fall, border_now;

    function automatic logic [GW-1:0] ext(input logic [WIDTH-1:0] p);
        return {3'b000, p};
    endfunction

    // The sums reach 4*(2^WIDTH-1) at most, so each difference fits in GW signed bits.
    // frame_synced keeps the output masked after a reset until a real vsync edge
    // restarts line counting.
    always_comb begin
        gx_pos  = ext(c2_r0) + (ext(c2_r1) << 1) + ext(c2_r2);
        gx_neg  = ext(c0_r0) + (ext(c0_r1) << 1) + ext(c0_r2);
        gy_pos  = ext(c0_r2) + (ext(c1_r2) << 1) + ext(c2_r2);
        gy_neg  = ext(c0_r0) + (ext(c1_r0) << 1) + ext(c2_r0);
        abs_gx  = gx[GW-1] ? (~gx + G_ONE) : gx;
        abs_gy  = gy[GW-1] ? (~gy + G_ONE) : gy;
        mag     = abs_gx + abs_gy;
        mag_sat = (|mag[GW-1:WIDTH]) ? '1 : mag[WIDTH-1:0];

        vs_rise = in_vsync & ~vs_dly[0];
        de_fall = de_dly[0] & ~in_de;

        border_now = ~de_dly[0]
                   | ~frame_synced
                   | ~(|line_cnt[ROW_W-1:1])
                   | (col_cnt == '0)
                   | (col_cnt == (h_size - COL_ONE));
    end

    // The border flag travels one stage behind the window so that it
    // reaches the M register together with the centre pixel's gradient.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (rst) begin
                c0_r0    <= '0;
                c0_r1    <= '0;
                c0_r2    <= '0;
                c1_r0    <= '0;
                c1_r1    <= '0;
                c1_r2    <= '0;
                c2_r0    <= '0;
                c2_r1    <= '0;
                c2_r2    <= '0;
                border_w <= 1'b0;
                border_g <= 1'b0;
                gx       <= '0;
                gy       <= '0;
                dout     <= '0;
            end else begin
                c0_r0    <= c1_r0;
                c0_r1    <= c1_r1;
                c0_r2    <= c1_r2;
                c1_r0    <= c2_r0;
                c1_r1    <= c2_r1;
                c1_r2    <= c2_r2;
                c2_r0    <= row0;
                c2_r1    <= row1;
                c2_r2    <= row2;
                border_w <= border_now;
                gx       <= gx_pos - gx_neg;
                gy       <= gy_pos - gy_neg;
                border_g <= border_w;
                dout     <= border_g ? '0 : mag_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ce) begin
            if (rst) begin
                de_dly <= '0;
                hs_dly <= '0;
                vs_dly <= '0;
            end else begin
                de_dly <= {de_dly[2:0], in_de};
                hs_dly <= {hs_dly[2:0], in_hsync};
                vs_dly <= {vs_dly[2:0], in_vsync};
            end
        end
    end

    // col_cnt is the index of the pixel about to become the window centre.
    // A vsync rise takes priority over a line increment on the same edge.
    always_ff @(posedge clk) begin
        if (ce) begin
            if (rst) begin
                col_cnt      <= '0;
                line_cnt     <= '0;
                frame_synced <= 1'b0;
            end else begin
                col_cnt <= de_dly[0] ? (col_cnt + COL_ONE) : '0;
                if (vs_rise) begin
                    line_cnt     <= '0;
                    frame_synced <= 1'b1;
                end else if (de_fall && (line_cnt != '1)) begin
                    line_cnt <= line_cnt + LINE_ONE;
                end
            end
        end
    end

    assign out_de    = de_dly[3];
    assign out_hsync = hs_dly[3];
    assign out_vsync = vs_dly[3];

endmodule

// File: tb/tb_sobel_context_3x3.sv
// tb_sobel_context_3x3
//
// Drives frames of line-delay taps into sobel_context_3x3. A frame-level model
// keeps the full sample history since the last reset. From that history it
// derives the column and line position of every centre pixel, the border rule
// and the Sobel sum. It predicts every output after each ce edge. Per-test
// statistics of the DUT output are also pinned to hand-computed values.
// ROW_W is reduced to 3 so that line-counter saturation is reached in short frames.

module tb_sobel_context_3x3;

    localparam int WIDTH    = 8;
    localparam int COL_W    = 11;
    localparam int ROW_W    = 3;
    localparam int MAXS     = 16384;
    localparam int LINE_MAX = (1 << ROW_W) - 1;
    localparam int PIX_MAX  = (1 << WIDTH) - 1;

    localparam int M_FLAT    = 0;
    localparam int M_VSTEP   = 1;
    localparam int M_HSAT    = 2;
    localparam int M_IMPULSE = 3;
    localparam int M_H3      = 4;
    localparam int M_RAND    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             ce;
    logic [WIDTH-1:0] row0, row1, row2;
    logic             in_de, in_hsync, in_vsync;
    logic [COL_W-1:0] h_size;
    logic [WIDTH-1:0] dout;
    logic             out_de, out_hsync, out_vsync;

    sobel_context_3x3 #(.WIDTH(WIDTH), .COL_W(COL_W), .ROW_W(ROW_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .row0      (row0),
        .row1      (row1),
        .row2      (row2),
        .in_de     (in_de),
        .in_hsync  (in_hsync),
        .in_vsync  (in_vsync),
        .h_size    (h_size),
        .dout      (dout),
        .out_de    (out_de),
        .out_hsync (out_hsync),
        .out_vsync (out_vsync)
    );

    always #5 clk = ~clk;

    int total_checks = 0;
    int bad_checks   = 0;

    // Sample history since the last effective reset, one entry per ce edge
    int h_r0 [MAXS];
    int h_r1 [MAXS];
    int h_r2 [MAXS];
    bit h_de [MAXS];
    bit h_hs [MAXS];
    bit h_vs [MAXS];
    int h_line [MAXS];
    bit h_sync [MAXS];
    int n_samples   = 0;
    bit model_valid = 1'b0;

    int exp_dout = 0;
    bit exp_de   = 1'b0;
    bit exp_hs   = 1'b0;
    bit exp_vs   = 1'b0;
    bit fresh    = 1'b0;

    int stat_nonzero = 0;
    int stat_sum     = 0;
    int stat_max     = 0;

    int ce_mode = 0;
    int ce_idx  = 0;
    bit ce_pattern [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int tap(input int k, input int r);
        if (k < 0 || k >= n_samples) return 0;
        case (r)
            0:       return h_r0[k];
            1:       return h_r1[k];
            default: return h_r2[k];
        endcase
    endfunction

    function automatic int colSum(input int k);
        return tap(k, 0) + 2 * tap(k, 1) + tap(k, 2);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference model: after each ce edge, predict the outputs for the pixel
    // that sat three samples back.
    initial begin
        forever begin
            int k, t, col, j, gxv, gyv, mag, pline;
            bit psync, pvs, pde, masked;
            @(posedge clk);
            fresh = (ce === 1'b1);
            if (ce === 1'b1) begin
                if (rst === 1'b1) begin
                    n_samples   = 0;
                    model_valid = 1'b1;
                    exp_dout    = 0;
                    exp_de      = 1'b0;
                    exp_hs      = 1'b0;
                    exp_vs      = 1'b0;
                end else if (model_valid) begin
                    k = n_samples;
                    if (k >= MAXS) begin
                        bad_checks++;
                        $display("[TB] FAIL model_depth: got %0d, expected below %0d", k, MAXS);
                        $fatal(1, "[TB] model history exhausted");
                    end
                    h_r0[k] = int'(row0);
                    h_r1[k] = int'(row1);
                    h_r2[k] = int'(row2);
                    h_de[k] = in_de;
                    h_hs[k] = in_hsync;
                    h_vs[k] = in_vsync;
                    pline = (k > 0) ? h_line[k-1] : 0;
                    psync = (k > 0) ? h_sync[k-1] : 1'b0;
                    pvs   = (k > 0) ? h_vs[k-1]   : 1'b0;
                    pde   = (k > 0) ? h_de[k-1]   : 1'b0;
                    h_line[k] = pline;
                    h_sync[k] = psync;
                    if (in_vsync && !pvs) begin
                        h_line[k] = 0;
                        h_sync[k] = 1'b1;
                    end else if (pde && !in_de) begin
                        h_line[k] = (pline < LINE_MAX) ? pline + 1 : LINE_MAX;
                    end
                    n_samples = k + 1;

                    t = k - 3;
                    if (t < 0) begin
                        exp_dout = 0;
                        exp_de   = 1'b0;
                        exp_hs   = 1'b0;
                        exp_vs   = 1'b0;
                    end else begin
                        col = 0;
                        j   = t - 1;
                        while (j >= 0 && h_de[j]) begin
                            col++;
                            j--;
                        end
                        masked = !h_de[t] || !h_sync[t] || (h_line[t] < 2) ||
                                 (col == 0) || (col == int'(h_size) - 1);
                        gxv = colSum(t + 1) - colSum(t - 1);
                        gyv = (tap(t-1, 2) + 2 * tap(t, 2) + tap(t+1, 2)) -
                              (tap(t-1, 0) + 2 * tap(t, 0) + tap(t+1, 0));
                        mag = iabs(gxv) + iabs(gyv);
                        if (mag > PIX_MAX) mag = PIX_MAX;
                        exp_dout = masked ? 0 : mag;
                        exp_de   = h_de[t];
                        exp_hs   = h_hs[t];
                        exp_vs   = h_vs[t];
                    end
                end
            end
        end
    end

    // Compare process: every cycle once the model has seen a reset
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                checkOutput("dout",      {24'd0, dout},     exp_dout);
                checkOutput("out_de",    {31'd0, out_de},    {31'd0, exp_de});
                checkOutput("out_hsync", {31'd0, out_hsync}, {31'd0, exp_hs});
                checkOutput("out_vsync", {31'd0, out_vsync}, {31'd0, exp_vs});
                if (fresh && dout != '0) begin
                    stat_nonzero++;
                    stat_sum += int'(dout);
                    if (int'(dout) > stat_max) stat_max = int'(dout);
                end
            end
        end
    end

    function automatic int pixel(input int mode, input int col, input int row);
        case (mode)
            M_FLAT:    return 100;
            M_VSTEP:   return (col >= 8) ? 10 : 0;
            M_HSAT:    return (row == 0) ? 0 : 255;
            M_IMPULSE: return (row == 1 && col == 5) ? 50 : 0;
            M_H3:      return col * 3 + row + 1;
            default:   return int'($urandom_range(PIX_MAX));
        endcase
    endfunction

    // One effective ce=1 cycle, optionally preceded by ce=0 cycles carrying junk
    task automatic applyStimulus(input bit de, input bit hs, input bit vs,
                                 input int p0, input int p1, input int p2, input bit do_rst);
        if (!do_rst) begin
            for (int g = 0; g < 8; g++) begin
                bit low;
                if (ce_mode == 1) begin
                    low    = !ce_pattern[ce_idx];
                    ce_idx = (ce_idx + 1) % 6;
                end else if (ce_mode == 2) begin
                    low = ($urandom_range(3) == 0);
                end else begin
                    low = 1'b0;
                end
                if (!low) break;
                @(negedge clk);
                ce       = 1'b0;
                rst      = (ce_mode == 2) ? ($urandom_range(4) == 0) : 1'b0;
                row0     = WIDTH'($urandom);
                row1     = WIDTH'($urandom);
                row2     = WIDTH'($urandom);
                in_de    = 1'($urandom);
                in_hsync = 1'($urandom);
                in_vsync = 1'($urandom);
            end
        end
        @(negedge clk);
        ce       = 1'b1;
        rst      = do_rst;
        row0     = WIDTH'(p0);
        row1     = WIDTH'(p1);
        row2     = WIDTH'(p2);
        in_de    = de;
        in_hsync = hs;
        in_vsync = vs;
    endtask

    task automatic clearStats();
        stat_nonzero = 0;
        stat_sum     = 0;
        stat_max     = 0;
    endtask

    // Frame: 2 vsync cycles, then per line 4 blanking cycles (hsync on the first
    // two) followed by w active pixels, then 'tail' blank cycles.
    task automatic runFrame(input int mode, input int w, input int lines, input int tail, input int rst_line);
        h_size = COL_W'(w);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0);
        for (int l = 0; l < lines; l++) begin
            for (int b = 0; b < 4; b++) applyStimulus(1'b0, (b < 2), 1'b0, 0, 0, 0, 1'b0);
            for (int c = 0; c < w; c++) begin
                int p0, p1, p2;
                p0 = pixel(mode, c, 0);
                p1 = pixel(mode, c, 1);
                p2 = pixel(mode, c, 2);
                if (l == rst_line && c == 6) begin
                    applyStimulus(1'b1, 1'b0, 1'b0, p0, p1, p2, 1'b1);
                    applyStimulus(1'b1, 1'b0, 1'b0, p0, p1, p2, 1'b0);
                    checkOutput("rst_dout",  {24'd0, dout},     0);
                    checkOutput("rst_de",    {31'd0, out_de},    0);
                    checkOutput("rst_hsync", {31'd0, out_hsync}, 0);
                    checkOutput("rst_vsync", {31'd0, out_vsync}, 0);
                    clearStats();
                end else begin
                    applyStimulus(1'b1, 1'b0, 1'b0, p0, p1, p2, 1'b0);
                end
            end
        end
        for (int i = 0; i < tail; i++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        bad_checks++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        ce       = 1'b1;
        row0     = '0;
        row1     = '0;
        row2     = '0;
        in_de    = 1'b0;
        in_hsync = 1'b0;
        in_vsync = 1'b0;
        h_size   = COL_W'(16);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset released");

        clearStats();
        runFrame(M_FLAT, 16, 8, 8, -1);
        checkOutput("flat_nonzero", stat_nonzero, 0);

        clearStats();
        runFrame(M_VSTEP, 16, 8, 8, -1);
        checkOutput("vstep_count", stat_nonzero, 12);
        checkOutput("vstep_sum",   stat_sum,     480);
        checkOutput("vstep_max",   stat_max,     40);

        clearStats();
        runFrame(M_HSAT, 16, 8, 8, -1);
        checkOutput("hsat_count", stat_nonzero, 84);
        checkOutput("hsat_sum",   stat_sum,     84 * 255);
        checkOutput("hsat_max",   stat_max,     255);

        clearStats();
        ce_mode = 1;
        ce_idx  = 0;
        runFrame(M_IMPULSE, 16, 8, 8, -1);
        ce_mode = 0;
        checkOutput("impulse_count", stat_nonzero, 12);
        checkOutput("impulse_sum",   stat_sum,     1200);

        clearStats();
        runFrame(M_H3, 3, 6, 8, -1);
        checkOutput("h3_count", stat_nonzero, 4);
        checkOutput("h3_sum",   stat_sum,     128);

        runFrame(M_RAND, 16, 8, 8, 4);
        checkOutput("reset_masked", stat_nonzero, 0);
        runFrame(M_RAND, 16, 8, 8, -1);

        ce_mode = 2;
        for (int f = 0; f < 6; f++) begin
            runFrame(M_RAND, int'($urandom_range(14, 4)), 10, 8, -1);
        end
        runFrame(M_RAND, 12, 10, 0, -1);
        runFrame(M_RAND, 12, 10, 8, -1);
        ce_mode = 0;
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
